uart_tx_core: RTL and testbench

//  Transmit half of the UART: serialises one data word per request into a standard async frame
//  (start, DATA_BITS LSB-first, optional parity, 1 or 2 stops) at a selectable baud rate.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_baud_gen.sv | 48 ++++
 rtl/uart_tx_core.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, BaudRate/ParityType encodings and bit-period divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } txState_t;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baudRate_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parityType_t;

  localparam int unsigned BAUD_BASE = 2400;

  // Clocks per bit, rounded to nearest: baud doubles with each BaudRate step.
  function automatic int unsigned baudDivisor(int unsigned clkHz, logic [1:0] baudRate);
    int unsigned baud;
    baud = BAUD_BASE << baudRate;
    return (clkHz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period divisor counter: counts 0..DIV-1 while enabled and pulses bitTick on the last count.
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] baudRate,
  output logic       bitTick
);

  localparam int unsigned MAX_DIV = baudDivisor(CLK_FREQ_HZ, 2'b00);
  localparam int          CNT_W   = $clog2(MAX_DIV);

  localparam logic [CNT_W-1:0] TC_2400  = CNT_W'(baudDivisor(CLK_FREQ_HZ, 2'b00) - 1);
  localparam logic [CNT_W-1:0] TC_4800  = CNT_W'(baudDivisor(CLK_FREQ_HZ, 2'b01) - 1);
  localparam logic [CNT_W-1:0] TC_9600  = CNT_W'(baudDivisor(CLK_FREQ_HZ, 2'b10) - 1);
  localparam logic [CNT_W-1:0] TC_19200 = CNT_W'(baudDivisor(CLK_FREQ_HZ, 2'b11) - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] termCount;

  always_comb begin
    termCount = TC_2400;
    case (baudRate)
      2'b00:   termCount = TC_2400;
      2'b01:   termCount = TC_4800;
      2'b10:   termCount = TC_9600;
      default: termCount = TC_19200;
    endcase
  end

  assign bitTick = enable && !clear && (count == termCount);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bitTick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, 1 or 2 stop bits.
//  state     | meaning
//  ST_IDLE   | line high, waiting for TxStart
//  ST_START  | start bit (0)
//  ST_DATA   | payload bits, shreg[0] on the line
//  ST_PARITY | parity bit (odd/even only)
//  ST_STOP   | stop bit(s) (1)
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DATA_BITS   = 8
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic [1:0]           BaudRate,
  input  logic [1:0]           ParityType,
  input  logic                 StopBits,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 TxOut,
  output logic                 Busy,
  output logic                 Done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  txState_t             state, stateNext;
  logic                 txOutReg, txOutNext;
  logic                 busyReg, busyNext;
  logic                 doneReg, doneNext;
  logic [DATA_BITS-1:0] shreg, shregNext;
  logic [IDX_W-1:0]     bitIdx, bitIdxNext;
  logic                 stopCnt, stopCntNext;
  logic                 parityAcc, parityAccNext;
  logic [1:0]           baudLatch, baudLatchNext;
  logic [1:0]           parityLatch, parityLatchNext;
  logic                 stopLatch, stopLatchNext;
  logic                 bitTick;
  logic                 parityEn;
  logic                 parityBit;

  uart_tx_baud_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) uBaudGen (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .enable  (state != ST_IDLE),
    .clear   (state == ST_IDLE),
    .baudRate(baudLatch),
    .bitTick (bitTick)
  );

  assign parityEn  = (parityLatch == PAR_ODD) || (parityLatch == PAR_EVEN);
  assign parityBit = parityAcc ^ shreg[0];

  always_comb begin
    stateNext       = state;
    txOutNext       = txOutReg;
    busyNext        = busyReg;
    doneNext        = 1'b0;
    shregNext       = shreg;
    bitIdxNext      = bitIdx;
    stopCntNext     = stopCnt;
    parityAccNext   = parityAcc;
    baudLatchNext   = baudLatch;
    parityLatchNext = parityLatch;
    stopLatchNext   = stopLatch;

    case (state)
      ST_IDLE: begin
        txOutNext = 1'b1;
        busyNext  = 1'b0;
        if (TxStart) begin
          shregNext       = TxData;
          baudLatchNext   = BaudRate;
          parityLatchNext = ParityType;
          stopLatchNext   = StopBits;
          bitIdxNext      = '0;
          stopCntNext     = 1'b0;
          parityAccNext   = 1'b0;
          txOutNext       = 1'b0;
          busyNext        = 1'b1;
          stateNext       = ST_START;
        end
      end

      ST_START: begin
        if (bitTick) begin
          txOutNext = shreg[0];
          stateNext = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bitTick) begin
          parityAccNext = parityBit;
          shregNext     = shreg >> 1;
          if (bitIdx == LAST_IDX) begin
            if (parityEn) begin
              // parityBit now covers every payload bit
              txOutNext = (parityLatch == PAR_ODD) ? ~parityBit : parityBit;
              stateNext = ST_PARITY;
            end else begin
              txOutNext = 1'b1;
              stateNext = ST_STOP;
            end
          end else begin
            bitIdxNext = bitIdx + 1'b1;
            txOutNext  = shreg[1];
          end
        end
      end

      ST_PARITY: begin
        if (bitTick) begin
          txOutNext = 1'b1;
          stateNext = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bitTick) begin
          if (stopLatch && !stopCnt) begin
            stopCntNext = 1'b1;
          end else begin
            stopCntNext = 1'b0;
            busyNext    = 1'b0;
            doneNext    = 1'b1;
            stateNext   = ST_IDLE;
          end
        end
      end

      default: begin
        txOutNext = 1'b1;
        busyNext  = 1'b0;
        stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= ST_IDLE;
      txOutReg    <= 1'b1;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      shreg       <= '0;
      bitIdx      <= '0;
      stopCnt     <= 1'b0;
      parityAcc   <= 1'b0;
      baudLatch   <= '0;
      parityLatch <= '0;
      stopLatch   <= 1'b0;
    end else begin
      state       <= stateNext;
      txOutReg    <= txOutNext;
      busyReg     <= busyNext;
      doneReg     <= doneNext;
      shreg       <= shregNext;
      bitIdx      <= bitIdxNext;
      stopCnt     <= stopCntNext;
      parityAcc   <= parityAccNext;
      baudLatch   <= baudLatchNext;
      parityLatch <= parityLatchNext;
      stopLatch   <= stopLatchNext;
    end
  end

  assign TxOut = txOutReg;
  assign Busy  = busyReg;
  assign Done  = doneReg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed and random frames against a bit-list frame model.
module tb_uart_tx_core;
  import uart_pkg::*;

  // Scaled-down clock keeps frames short; the 50 MHz divisors are checked on the package function.
  localparam int unsigned CLK_HZ = 1_000_000;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic [1:0] BaudRate = '0;
  logic [1:0] ParityType = '0;
  logic       StopBits = 1'b0;
  logic       TxStart = 1'b0;
  logic [7:0] TxData = '0;
  logic       TxOut, Busy, Done;

  int checks = 0;
  int errors = 0;
  int off = 0;

  logic [1:0] nBr, nPt;
  logic       nSb;
  logic [7:0] nData;

  uart_tx_core #(
    .CLK_FREQ_HZ(CLK_HZ),
    .DATA_BITS  (8)
  ) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .BaudRate  (BaudRate),
    .ParityType(ParityType),
    .StopBits  (StopBits),
    .TxStart   (TxStart),
    .TxData    (TxData),
    .TxOut     (TxOut),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clock = ~Clock;

  function automatic int expDiv(int unsigned clkHz, int br);
    real baud;
    baud = 2400.0;
    for (int j = 0; j < br; j++) baud = baud * 2.0;
    return $rtoi(real'(clkHz) / baud + 0.5);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepTo(int target);
    if (off < target) begin
      while (off < target) begin
        @(posedge Clock);
        off++;
      end
      #1;
    end
  endtask

  task automatic runFrame(input logic [1:0] br, input logic [1:0] pt, input logic sb,
                          input logic [7:0] data, input bit preAcc, input bit hold,
                          input bit midPulse, input string tag);
    bit q[$];
    int div, n, ones;
    q.push_back(1'b0);
    for (int j = 0; j < 8; j++) q.push_back(data[j]);
    ones = $countones(data);
    if (pt == 2'b10) q.push_back(bit'(ones % 2));
    if (pt == 2'b01) q.push_back(bit'(1 - ones % 2));
    q.push_back(1'b1);
    if (sb) q.push_back(1'b1);
    div = expDiv(CLK_HZ, int'(br));
    n = q.size();

    if (!preAcc) begin
      @(negedge Clock);
      BaudRate = br; ParityType = pt; StopBits = sb; TxData = data; TxStart = 1'b1;
    end
    @(posedge Clock);
    #1;
    off = 0;
    if (!hold) TxStart = 1'b0;
    check($sformatf("%s accept Busy", tag), 32'(Busy), 32'd1);
    check($sformatf("%s accept Done", tag), 32'(Done), 32'd0);

    for (int i = 0; i < n; i++) begin
      stepTo(i * div);
      check($sformatf("%s bit%0d first", tag, i), 32'(TxOut), 32'(q[i]));
      stepTo(i * div + div / 2);
      check($sformatf("%s bit%0d centre", tag, i), 32'(TxOut), 32'(q[i]));
      if (midPulse && i == 3) begin
        TxStart = 1'b1; BaudRate = ~br; TxData = ~data; ParityType = pt ^ 2'b11; StopBits = ~sb;
        stepTo(off + 1);
        TxStart = 1'b0;
      end
      stepTo((i + 1) * div - 1);
      check($sformatf("%s bit%0d last", tag, i), 32'(TxOut), 32'(q[i]));
    end
    check($sformatf("%s end Busy", tag), 32'(Busy), 32'd1);
    check($sformatf("%s end Done", tag), 32'(Done), 32'd0);

    stepTo(n * div);
    check($sformatf("%s done pulse", tag), 32'(Done), 32'd1);
    check($sformatf("%s done Busy", tag), 32'(Busy), 32'd0);
    check($sformatf("%s done TxOut", tag), 32'(TxOut), 32'd1);
    if (hold) begin
      BaudRate = nBr; ParityType = nPt; StopBits = nSb; TxData = nData;
    end else begin
      stepTo(n * div + 1);
      check($sformatf("%s post Done", tag), 32'(Done), 32'd0);
      check($sformatf("%s post Busy", tag), 32'(Busy), 32'd0);
      check($sformatf("%s post TxOut", tag), 32'(TxOut), 32'd1);
    end
  endtask

  initial begin
    int div, doneSeen, lowSeen;

    repeat (3) @(negedge Clock);
    check("reset TxOut", 32'(TxOut), 32'd1);
    check("reset Busy", 32'(Busy), 32'd0);
    check("reset Done", 32'(Done), 32'd0);
    ResetN = 1'b1;
    repeat (2) @(negedge Clock);

    check("div 2400", baudDivisor(50_000_000, 2'b00), 32'd20833);
    check("div 4800", baudDivisor(50_000_000, 2'b01), 32'd10417);
    check("div 9600", baudDivisor(50_000_000, 2'b10), 32'd5208);
    check("div 19200", baudDivisor(50_000_000, 2'b11), 32'd2604);

    runFrame(2'b10, 2'b00, 1'b0, 8'hA5, 0, 0, 0, "a5");
    runFrame(2'b11, 2'b10, 1'b0, 8'h03, 0, 0, 0, "even03");
    runFrame(2'b11, 2'b01, 1'b0, 8'h03, 0, 0, 0, "odd03");
    runFrame(2'b00, 2'b01, 1'b1, 8'hFF, 0, 0, 0, "ff2stop");
    runFrame(2'b01, 2'b10, 1'b0, 8'($urandom), 0, 0, 1, "midreq");

    nBr = 2'($urandom); nPt = 2'($urandom); nSb = 1'($urandom); nData = 8'($urandom);
    runFrame(2'b11, 2'b00, 1'b1, 8'($urandom), 0, 1, 0, "held1");
    runFrame(nBr, nPt, nSb, nData, 1, 0, 0, "held2");

    // Reset during DATA
    div = expDiv(CLK_HZ, 3);
    @(negedge Clock);
    BaudRate = 2'b11; ParityType = 2'b00; StopBits = 1'b0; TxData = 8'h00; TxStart = 1'b1;
    @(posedge Clock);
    #1;
    TxStart = 1'b0;
    repeat (3 * div) @(posedge Clock);
    #1;
    ResetN = 1'b0;
    #1;
    check("midrst TxOut", 32'(TxOut), 32'd1);
    check("midrst Busy", 32'(Busy), 32'd0);
    check("midrst Done", 32'(Done), 32'd0);
    repeat (3) @(negedge Clock);
    ResetN = 1'b1;
    doneSeen = 0;
    lowSeen = 0;
    repeat (12 * div) begin
      @(negedge Clock);
      if (Done) doneSeen++;
      if (!TxOut) lowSeen++;
    end
    check("midrst no Done", 32'(doneSeen), 32'd0);
    check("midrst line idle", 32'(lowSeen), 32'd0);

    for (int r = 0; r < 6; r++) begin
      runFrame(2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 0, 0, 0,
               $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
